sha2_256_core: RTL
==================

# sha2_256_core

Synthesisable SHA-224/SHA-256 compression engine; the RTL counterpart of the SHA-2 32-bit class model in the hash package. It accepts one pre-padded 512-bit message block per handshake and chains the intermediate hash across blocks. It presents a 256-bit digest after each block. Round throughput is set by an unroll parameter, and the SHA-224 or SHA-256 variant is chosen per message. Padding and length encoding are the caller's job. The class models serve as the golden reference for verification.

## Interface
- UNROLL, 1, rounds per clock; legal values 1, 2, 4; any other value is a compile-time error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- blk_valid  in  1  a block is offered on blk_data.
- blk_ready  out  1  engine idle, can accept a block; reset 1.
- blk_data  in  512  message block; word W0 = bits 511:480, big-endian per FIPS 180-4.
- blk_first  in  1  qualified by the accept; block starts a new message and H is reloaded from the IV.
- mode_224  in  1  sampled only when blk_first is accepted; 1 = SHA-224 IV and output format.
- dig_valid  out  1  dig_data holds the hash after the most recent block; reset 0.
- dig_data  out  256  current H0..H7, H0 in bits 255:224; reset all-zero.
- busy  out  1  rounds in progress; equals ~blk_ready; reset 0.

## Operation
- Accept condition: blk_valid & blk_ready on a rising edge. blk_data, blk_first and mode_224 are captured, so the caller may change them afterwards.
- States:
  - IDLE → ROUND on accept.
  - ROUND → ROUND while the round counter is below 64−UNROLL.
  - ROUND → UPDATE when the final UNROLL rounds are done.
  - UPDATE → IDLE unconditionally.
- On accept with blk_first=1:
  - The H registers load the IV (SHA-256 or SHA-224 per mode_224).
  - The stored mode flag updates.
  - The working variables a..h load that same IV.
- On accept with blk_first=0: a..h load the current H, and the mode flag is kept.
- Reset value of H is the SHA-256 IV, with the mode flag at 256. A block accepted after reset without blk_first therefore hashes as SHA-256 from the IV.
- Message schedule: a 16-word shift register loaded from blk_data.
  - Each round consumes W[t]; for t≥16, W[t] = σ1(W[t−2]) + W[t−7] + σ0(W[t−15]) + W[t−16].
  - The register shifts by UNROLL words per cycle.
- Round constants: a 64-entry K table indexed by the round counter (6 bits) plus the unroll lane.
- All adds are 32-bit modulo 2^32, and carries are discarded.
- UPDATE: Hi ← Hi + working variable (mod 2^32), and dig_valid is set to 1.
- dig_data output format:
  - SHA-256: H0..H7.
  - SHA-224: H0..H6 in bits 255:32, bits 31:0 forced to zero. H7 is retained internally for chaining.
- dig_valid clears on the accept edge of the next block and stays low until that block's UPDATE. dig_data is frozen at its last value while busy.
- blk_valid is ignored while busy. No block is queued, and the caller must hold blk_valid until accepted.
- rst asserted at any time returns the engine to IDLE:
  - H returns to the SHA-256 IV, dig_valid and dig_data go to 0, and the round counter goes to 0.
  - Any in-flight block is discarded, and no digest is emitted.

## Timing
- Accept edge = edge 0. Round edges are 1..64/UNROLL. The UPDATE edge is 64/UNROLL+1.
- dig_valid and blk_ready both rise after edge 64/UNROLL+1 (65 / 33 / 17 cycles for UNROLL 1 / 2 / 4).
- blk_ready and dig_valid are high together in IDLE. A new block may be accepted on the edge immediately after UPDATE, giving a block period of 64/UNROLL+1 cycles.
- Simultaneous events:
  - Accept and dig_valid high on the same edge: dig_valid falls and the next block starts.
  - Reset overrides any accept on the same edge.

## Test plan
- "abc" in a single padded block (61626380, thirteen zero words, 00000018) with blk_first=1, mode_224=0 → dig_data = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block with mode_224=1 → dig_data = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
- Two-block chaining with "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first block blk_first=1, second blk_first=0) → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Repeat for UNROLL=1, 2 and 4; dig_valid rises 65, 33 and 17 cycles after each accept respectively.
- Empty message (80000000, 15 zero words) sent back-to-back after the "abc" SHA-224 message with blk_first=1, mode_224=0 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. This confirms the IV reload and mode switch.
- Hold blk_valid high during busy with changing blk_data → the result matches the captured block only, and blk_ready stays 0 for exactly 64/UNROLL+1 cycles.
- Assert rst for one cycle at round 30 → blk_ready=1, dig_valid=0 and dig_data=0 immediately. Then send the "abc" block without blk_first → the SHA-256 "abc" digest.

Source files
------------

// File: rtl/sha2_256_core.sv
// sha2_256_core: SHA-224/SHA-256 compression engine, one pre-padded 512-bit block per
// handshake, intermediate hash chained across blocks, UNROLL rounds per clock.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   blk_valid/ready block handshake; blk_data word W0 in bits 511:480
//   blk_first       block starts a new message (H reloaded from the IV)
//   mode_224        variant select, sampled with blk_first
//   dig_valid       dig_data holds the hash after the most recent block
//   dig_data        H0..H7 (H7 zeroed in SHA-224 mode), H0 in bits 255:224
//   busy            rounds in progress (~blk_ready)
module sha2_256_core #(
   parameter int unsigned UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         mode_224,
   output logic         dig_valid,
   output logic [255:0] dig_data,
   output logic         busy
);
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned ROUNDS = 64;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS - UNROLL);

   localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sha2_256_core: UNROLL must be 1, 2 or 4");
   end

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

   state_t           state, state_nx;
   logic             accept, round_en, update_en;
   logic [CNT_W-1:0] cnt;
   logic             m224;
   logic [31:0]      h        [8];
   logic [31:0]      work     [8];
   logic [31:0]      work_nx  [8];
   logic [31:0]      sched    [16];
   logic [31:0]      sched_nx [16];
   logic [31:0]      t1, t2, w_new;
   logic [255:0]     iv_sel, h_sum;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:   if (blk_valid) state_nx = S_ROUND;
         S_ROUND:  if (cnt == LAST_CNT) state_nx = S_UPDATE;
         S_UPDATE: state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      accept    = 1'b0;
      round_en  = 1'b0;
      update_en = 1'b0;
      unique case (state)
         S_IDLE:   accept    = blk_valid;
         S_ROUND:  round_en  = 1'b1;
         S_UPDATE: update_en = 1'b1;
         default:  ;
      endcase
   end

   assign blk_ready = (state == S_IDLE);
   assign busy      = ~blk_ready;
   assign iv_sel    = mode_224 ? IV_224 : IV_256;

   // UNROLL chained rounds; W[0] of the shift register is the word for the current round
   always_comb begin
      work_nx  = work;
      sched_nx = sched;
      t1       = '0;
      t2       = '0;
      w_new    = '0;
      for (int i = 0; i < int'(UNROLL); i++) begin
         t1 = work_nx[7] + bsig1(work_nx[4]) + ((work_nx[4] & work_nx[5]) ^ (~work_nx[4] & work_nx[6]))
            + K_TAB[cnt + CNT_W'(i)] + sched_nx[0];
         t2 = bsig0(work_nx[0]) + ((work_nx[0] & work_nx[1]) ^ (work_nx[0] & work_nx[2]) ^ (work_nx[1] & work_nx[2]));
         w_new = ssig1(sched_nx[14]) + sched_nx[9] + ssig0(sched_nx[1]) + sched_nx[0];
         for (int j = 7; j > 0; j--) work_nx[j] = work_nx[j-1];
         work_nx[4] = work_nx[4] + t1;   // slot 4 now holds the old d
         work_nx[0] = t1 + t2;
         for (int j = 0; j < 15; j++) sched_nx[j] = sched_nx[j+1];
         sched_nx[15] = w_new;
      end
   end

   // Feed-forward sum, flattened with H0 in the top word
   always_comb begin
      h_sum = '0;
      for (int i = 0; i < 8; i++) h_sum[255-32*i -: 32] = h[i] + work[i];
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         m224      <= 1'b0;
         dig_valid <= 1'b0;
         dig_data  <= '0;
         for (int i = 0; i < 8; i++) begin
            h[i]    <= IV_256[255-32*i -: 32];
            work[i] <= '0;
         end
         for (int i = 0; i < 16; i++) sched[i] <= '0;
      end else begin
         if (accept) begin
            cnt       <= '0;
            dig_valid <= 1'b0;
            for (int i = 0; i < 16; i++) sched[i] <= blk_data[511-32*i -: 32];
            if (blk_first) begin
               m224 <= mode_224;
               for (int i = 0; i < 8; i++) begin
                  h[i]    <= iv_sel[255-32*i -: 32];
                  work[i] <= iv_sel[255-32*i -: 32];
               end
            end else begin
               for (int i = 0; i < 8; i++) work[i] <= h[i];
            end
         end
         if (round_en) begin
            cnt   <= cnt + CNT_W'(UNROLL);
            work  <= work_nx;
            sched <= sched_nx;
         end
         if (update_en) begin
            for (int i = 0; i < 8; i++) h[i] <= h_sum[255-32*i -: 32];
            dig_valid <= 1'b1;
            dig_data  <= m224 ? {h_sum[255:32], 32'h0} : h_sum;
         end
      end
   end

endmodule
